// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//
// Front-end controller for an AES key-expansion engine. It accepts a cipher
// key, starts the external expansion engine, and captures the expanded round
// keys when the engine finishes. It then serves round-key reads to two
// requesters through a round-robin arbiter. Round key 0 is the cipher key
// itself. Round keys 1..NRK come from the captured engine result.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst           asynchronous, active-high reset
//   key_load      one-cycle request to expand key_in
//   key_in        cipher key, sampled when key_load is accepted
//   key_busy      high while an expansion is in flight (EXPAND)
//   key_ready     high while round keys are valid (READY)
//   ks_err        one-cycle pulse when the engine fails to finish in time
//   ks_start      one-cycle start pulse to the expansion engine
//   ks_key        registered key presented to the engine
//   ks_finish     engine completion pulse
//   ks_roundkeys  engine result; round key r sits at [128*(NRK-r) +: 128]
//   req0_*/req1_* round-key read requests (valid + round index)
//   gnt0/gnt1     combinational one-cycle grants, at most one high
//   rk_out        registered round-key data, one cycle after the grant
//   rk_valid      rk_out is valid this cycle
//   rk_owner      requester served by the current rk_valid
//   rk_err        requested index was above NRK; rk_out is zero then
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
  parameter int NRK     = 10,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_load,
  input  logic [127:0]       key_in,
  output logic               key_busy,
  output logic               key_ready,
  output logic               ks_err,
  output logic               ks_start,
  output logic [127:0]       ks_key,
  input  logic               ks_finish,
  input  logic [128*NRK-1:0] ks_roundkeys,
  input  logic               req0_valid,
  input  logic [3:0]         req0_idx,
  input  logic               req1_valid,
  input  logic [3:0]         req1_idx,
  output logic               gnt0,
  output logic               gnt1,
  output logic [127:0]       rk_out,
  output logic               rk_valid,
  output logic               rk_owner,
  output logic               rk_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [127:0]        ks_key_q;
  logic [128*NRK-1:0]  store_q;
  logic                ks_start_q;
  logic                ks_err_q;
  logic                prio_q;
  logic [127:0]        rk_out_q;
  logic                rk_valid_q;
  logic                rk_owner_q;
  logic                rk_err_q;

  logic                load_acc;
  logic                capture;
  logic                timeout_hit;
  logic                gnt0_c;
  logic                gnt1_c;
  logic [3:0]          sel_idx;
  logic                sel_err;
  logic [127:0]        sel_data;

  // State register. An asynchronous reset drops any expansion in flight, so a
  // late ks_finish from the engine lands in IDLE and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, timeout counting and arbitration. A key_load in IDLE or
  // READY wins over any round-key request in the same cycle. The counter
  // holds the number of EXPAND cycles already spent. It gives up after
  // TIMEOUT of them, but a ks_finish in the last allowed cycle still counts.
  // prio_q set means requester 1 currently has priority.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_acc    = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          load_acc = 1'b1;
          cnt_d    = '0;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        if (ks_finish) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = READY;
        end else if (cnt_q == TMAX) begin
          timeout_hit = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READY: begin
        if (key_load) begin
          load_acc = 1'b1;
          cnt_d    = '0;
          state_d  = EXPAND;
        end else if (req0_valid && (!req1_valid || !prio_q)) begin
          gnt0_c = 1'b1;
        end else if (req1_valid) begin
          gnt1_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Round-key lookup for the winning requester. Index 0 returns the cipher
  // key. Indices 1..NRK come from the captured store. Anything above NRK is
  // flagged and returns zero, so out-of-range data never leaks.
  always_comb begin
    sel_idx  = gnt1_c ? req1_idx : req0_idx;
    sel_err  = (int'(sel_idx) > NRK);
    sel_data = '0;
    if (!sel_err) begin
      if (sel_idx == 4'd0) begin
        sel_data = ks_key_q;
      end else begin
        for (int r = 1; r <= NRK; r++) begin
          if (int'(sel_idx) == r) begin
            sel_data = store_q[128*(NRK-r) +: 128];
          end
        end
      end
    end
  end

  // Datapath registers. The key is sampled only on an accepted load. The
  // engine result is copied only in the capture cycle, so later changes on
  // ks_roundkeys cannot disturb keys already being served. Read responses
  // appear one cycle after their grant, and the grant also flips priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      ks_key_q   <= '0;
      store_q    <= '0;
      ks_start_q <= 1'b0;
      ks_err_q   <= 1'b0;
      prio_q     <= 1'b0;
      rk_out_q   <= '0;
      rk_valid_q <= 1'b0;
      rk_owner_q <= 1'b0;
      rk_err_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ks_start_q <= load_acc;
      ks_err_q   <= timeout_hit;
      if (load_acc) begin
        ks_key_q <= key_in;
      end
      if (capture) begin
        store_q <= ks_roundkeys;
      end
      if (gnt0_c || gnt1_c) begin
        prio_q     <= gnt0_c;
        rk_valid_q <= 1'b1;
        rk_owner_q <= gnt1_c;
        rk_err_q   <= sel_err;
        rk_out_q   <= sel_data;
      end else begin
        rk_valid_q <= 1'b0;
        rk_err_q   <= 1'b0;
      end
    end
  end

  // Status outputs follow the state directly. key_ready therefore rises in
  // the first READY cycle, which is the cycle after ks_finish.
  assign key_busy  = (state_q == EXPAND);
  assign key_ready = (state_q == READY);
  assign ks_err    = ks_err_q;
  assign ks_start  = ks_start_q;
  assign ks_key    = ks_key_q;
  assign gnt0      = gnt0_c;
  assign gnt1      = gnt1_c;
  assign rk_out    = rk_out_q;
  assign rk_valid  = rk_valid_q;
  assign rk_owner  = rk_owner_q;
  assign rk_err    = rk_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
//
// Drives the key-schedule controller through directed scenarios and a
// randomized phase. Every cycle it compares the outputs against a behavioural
// model. The model tracks the mode, the captured key, a round-key array and
// the requester that currently has priority.
// ---------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

  localparam int NRK     = 10;
  localparam int TIMEOUT = 32;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;

  logic               clk = 1'b0;
  logic               rst;
  logic               key_load;
  logic [127:0]       key_in;
  logic               key_busy, key_ready, ks_err, ks_start;
  logic [127:0]       ks_key;
  logic               ks_finish;
  logic [128*NRK-1:0] ks_roundkeys;
  logic               req0_valid, req1_valid;
  logic [3:0]         req0_idx, req1_idx;
  logic               gnt0, gnt1;
  logic [127:0]       rk_out;
  logic               rk_valid, rk_owner, rk_err;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NRK(NRK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .key_load(key_load), .key_in(key_in),
    .key_busy(key_busy), .key_ready(key_ready),
    .ks_err(ks_err), .ks_start(ks_start), .ks_key(ks_key),
    .ks_finish(ks_finish), .ks_roundkeys(ks_roundkeys),
    .req0_valid(req0_valid), .req0_idx(req0_idx),
    .req1_valid(req1_valid), .req1_idx(req1_idx),
    .gnt0(gnt0), .gnt1(gnt1),
    .rk_out(rk_out), .rk_valid(rk_valid), .rk_owner(rk_owner), .rk_err(rk_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: mode 0 idle, 1 expanding, 2 keys ready.
  int           mMode;
  int           mCnt;
  logic [127:0] mKey;
  logic [127:0] mRound [1:NRK];
  logic         mPrio1;
  logic         eStart, eErr, eValid, eOwner, eRkErr;
  logic [127:0] eOut;

  logic         lastG0, lastG1;
  logic [1:0]   obsGnt;
  int           startPulses, busyCycles, errPulses;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [128*NRK-1:0] rndKeys();
    logic [128*NRK-1:0] v;
    for (int r = 0; r < NRK; r++) v[128*r +: 128] = rnd128();
    return v;
  endfunction

  task automatic modelReset();
    mMode  = 0;
    mCnt   = 0;
    mKey   = '0;
    mPrio1 = 1'b0;
    eStart = 1'b0;
    eErr   = 1'b0;
    eValid = 1'b0;
    eOwner = 1'b0;
    eRkErr = 1'b0;
    eOut   = '0;
    for (int r = 1; r <= NRK; r++) mRound[r] = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict grants, compare at the falling
  // edge, then advance the model at the rising edge.
  task automatic applyStimulus(input logic ld, input logic [127:0] k, input logic fin,
                               input logic v0, input logic [3:0] i0,
                               input logic v1, input logic [3:0] i1);
    logic g0, g1, nStart, nErr;
    int   idx;
    key_load   = ld;
    key_in     = k;
    ks_finish  = fin;
    req0_valid = v0;
    req0_idx   = i0;
    req1_valid = v1;
    req1_idx   = i1;
    if (rst) modelReset();
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && mMode == 2 && !ld) begin
      if (v0 && (!v1 || !mPrio1)) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
    end
    lastG0 = g0;
    lastG1 = g1;
    @(negedge clk);
    obsGnt = {gnt1, gnt0};
    if (ks_start) startPulses++;
    if (key_busy) busyCycles++;
    if (ks_err) errPulses++;
    checkOutput("key_busy",  {127'd0, key_busy},  {127'd0, mMode == 1});
    checkOutput("key_ready", {127'd0, key_ready}, {127'd0, mMode == 2});
    checkOutput("ks_start",  {127'd0, ks_start},  {127'd0, eStart});
    checkOutput("ks_err",    {127'd0, ks_err},    {127'd0, eErr});
    checkOutput("ks_key",    ks_key, mKey);
    checkOutput("gnt0",      {127'd0, gnt0},      {127'd0, g0});
    checkOutput("gnt1",      {127'd0, gnt1},      {127'd0, g1});
    checkOutput("rk_valid",  {127'd0, rk_valid},  {127'd0, eValid});
    if (eValid) begin
      checkOutput("rk_owner", {127'd0, rk_owner}, {127'd0, eOwner});
      checkOutput("rk_err",   {127'd0, rk_err},   {127'd0, eRkErr});
      checkOutput("rk_out",   rk_out, eOut);
    end
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      nStart = 1'b0;
      nErr   = 1'b0;
      if (g0 || g1) begin
        idx    = g1 ? int'(i1) : int'(i0);
        eValid = 1'b1;
        eOwner = g1;
        if (idx > NRK) begin
          eRkErr = 1'b1;
          eOut   = '0;
        end else begin
          eRkErr = 1'b0;
          eOut   = (idx == 0) ? mKey : mRound[idx];
        end
        mPrio1 = g0;
      end else begin
        eValid = 1'b0;
        eRkErr = 1'b0;
      end
      if (mMode == 1) begin
        if (fin) begin
          for (int r = 1; r <= NRK; r++) mRound[r] = ks_roundkeys[128*(NRK-r) +: 128];
          mMode = 2;
        end else begin
          mCnt++;
          if (mCnt >= TIMEOUT) begin
            mMode = 0;
            nErr  = 1'b1;
          end
        end
      end else if (ld) begin
        mKey   = k;
        mMode  = 1;
        mCnt   = 0;
        nStart = 1'b1;
      end
      eStart = nStart;
      eErr   = nErr;
    end
    #1;
    cyc++;
  endtask

  initial begin
    logic [128*NRK-1:0] capturedRk;
    logic               v0, v1, ld, fin;
    logic [3:0]         i0, i1;

    rst = 1'b1;
    key_load = 1'b0; key_in = '0; ks_finish = 1'b0; ks_roundkeys = '0;
    req0_valid = 1'b0; req0_idx = '0; req1_valid = 1'b0; req1_idx = '0;
    modelReset();
    startPulses = 0; busyCycles = 0; errPulses = 0;

    // Reset state.
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("rst_rk_out",   rk_out, '0);
    checkOutput("rst_rk_owner", {127'd0, rk_owner}, '0);
    checkOutput("rst_rk_err",   {127'd0, rk_err}, '0);
    checkOutput("rst_ks_key",   ks_key, '0);
    rst = 1'b0;

    // Load the reference key, engine finishes in the 11th EXPAND cycle.
    ks_roundkeys = rndKeys();
    capturedRk   = ks_roundkeys;
    startPulses = 0; busyCycles = 0;
    applyStimulus(1'b1, KEY0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    repeat (10) applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    ks_roundkeys = rndKeys();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("start_pulses", startPulses, 1);
    checkOutput("busy_cycles",  busyCycles, 11);

    // Simultaneous requests for round 0 and round 10.
    v0 = 1'b1; v1 = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, v0, 4'd0, v1, 4'd10);
    checkOutput("first_gnt",   obsGnt, 2'b01);
    checkOutput("rk_key0",     rk_out, KEY0);
    checkOutput("rk_owner0",   rk_owner, 0);
    if (lastG0) v0 = 1'b0;
    if (lastG1) v1 = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, v0, 4'd0, v1, 4'd10);
    checkOutput("second_gnt",  obsGnt, 2'b10);
    checkOutput("rk_round10",  rk_out, capturedRk[127:0]);
    checkOutput("rk_owner1",   rk_owner, 1);

    // Both requesters held continuously: grants alternate 0,1,0,1.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'($urandom_range(0, NRK)),
                    1'b1, 4'($urandom_range(0, NRK)));
      checkOutput("alternate", obsGnt, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Out-of-range index.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd12, 1'b0, 4'd0);
    checkOutput("oor_valid", rk_valid, 1);
    checkOutput("oor_err",   rk_err, 1);
    checkOutput("oor_data",  rk_out, '0);

    // Randomized traffic with occasional reloads and stray finishes.
    v0 = 1'b0; v1 = 1'b0; i0 = '0; i1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1'b1; i0 = 4'($urandom_range(0, 12)); end
      if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1'b1; i1 = 4'($urandom_range(0, 12)); end
      ld  = ($urandom_range(0, 29) == 0);
      fin = (mMode == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      ks_roundkeys = rndKeys();
      applyStimulus(ld, rnd128(), fin, v0, i0, v1, i1);
      if (lastG0) v0 = 1'b0;
      if (lastG1) v1 = 1'b0;
    end

    // Leave EXPAND if needed, then let an expansion time out.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    busyCycles = 0; errPulses = 0;
    applyStimulus(1'b1, rnd128(), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    repeat (40) applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    checkOutput("to_busy_cycles", busyCycles, TIMEOUT);
    checkOutput("to_err_pulses",  errPulses, 1);
    checkOutput("to_idle_busy",   key_busy, 0);
    checkOutput("to_idle_ready",  key_ready, 0);

    // key_load beats a request in READY.
    ks_roundkeys = rndKeys();
    applyStimulus(1'b1, rnd128(), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b1, rnd128(), 1'b0, 1'b1, 4'd3, 1'b1, 4'd4);
    checkOutput("ld_pri_gnt",  obsGnt, 2'b00);
    checkOutput("ld_pri_busy", key_busy, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

    // Reset mid-EXPAND, then a late finish must be ignored.
    applyStimulus(1'b1, rnd128(), 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      checkOutput("rst_abandon_ready", key_ready, 0);
    end
    checkOutput("rst_abandon_key", ks_key, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
